// File: rtl/kwta_gamma_sync.sv
// kwta_gamma_sync: k-winner-take-all over spike times within each gamma window
module kwta_gamma_sync #(
  parameter int NUM_INPUTS = 16,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH = 8,
  parameter int TIE_MODE = 0,
  localparam int KW = $clog2(NUM_INPUTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gamma_start_i,
  input  logic [KW-1:0]         k_cfg_i,
  input  logic [NUM_INPUTS-1:0] input_spikes_i,
  output logic [NUM_INPUTS-1:0] output_spikes_o,
  output logic                  inhibit_o,
  output logic [NUM_INPUTS-1:0] winner_mask_o,
  output logic [KW-1:0]         winner_count_o,
  output logic                  done_o
);
  localparam int GW = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1;
  localparam int PCW = $clog2(PULSE_WIDTH + 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] gcnt_q;
  logic [KW-1:0] k_eff_q, cnt_q, cnt_d, k_clamp, winner_count_q;
  logic [NUM_INPUTS-1:0] seen_q, won_q, winner_mask_q, new_ev, acc;
  logic [PCW-1:0] pc_q [NUM_INPUTS];
  logic [KW:0] room, taken, sum;
  logic inhibit_q, done_q, last;
  assign last = gcnt_q == GW'(GAMMA_CYCLE_WIDTH - 1);
  assign k_clamp = (k_cfg_i > KW'(NUM_INPUTS)) ? KW'(NUM_INPUTS) : k_cfg_i;
  assign inhibit_o = inhibit_q;
  assign done_o = done_q;
  assign winner_mask_o = winner_mask_q;
  assign winner_count_o = winner_count_q;
  // Window FSM: a strobe always (re)opens a window; the last window cycle closes it
  always_comb begin
    state_d = state_q;
    if (gamma_start_i) state_d = ACTIVE;
    else if (state_q == ACTIVE && last) state_d = IDLE;
  end
  // New first-spike events and which of them win, given the remaining winner slots
  always_comb begin
    new_ev = (state_q == ACTIVE && !gamma_start_i) ? input_spikes_i & ~seen_q : '0;
    room = (cnt_q < k_eff_q) ? {1'b0, k_eff_q - cnt_q} : '0;
    acc = '0;
    taken = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (new_ev[i] && room != '0 && (TIE_MODE == 0 || taken < room)) begin
        acc[i] = 1'b1;
        taken = taken + (KW+1)'(1);
      end
    end
    sum = {1'b0, cnt_q} + taken;
    cnt_d = (sum > (KW+1)'(NUM_INPUTS)) ? KW'(NUM_INPUTS) : sum[KW-1:0];
  end
  // A winner's line is high while its pulse counter is non-zero
  always_comb begin
    output_spikes_o = '0;
    for (int i = 0; i < NUM_INPUTS; i++) output_spikes_o[i] = |pc_q[i];
  end
  // Window bookkeeping, winner report and per-input pulse timers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gcnt_q <= '0;
      k_eff_q <= '0;
      cnt_q <= '0;
      seen_q <= '0;
      won_q <= '0;
      inhibit_q <= 1'b0;
      done_q <= 1'b0;
      winner_mask_q <= '0;
      winner_count_q <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) pc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q <= state_q == ACTIVE && last && !gamma_start_i;
      if (state_q == ACTIVE && last && !gamma_start_i) begin
        winner_mask_q <= won_q | acc;
        winner_count_q <= cnt_d;
      end
      if (gamma_start_i) begin
        gcnt_q <= '0;
        k_eff_q <= k_clamp;
        cnt_q <= '0;
        seen_q <= '0;
        won_q <= '0;
        inhibit_q <= k_clamp == '0;
        for (int i = 0; i < NUM_INPUTS; i++) pc_q[i] <= '0;
      end else begin
        gcnt_q <= (state_q == ACTIVE && !last) ? gcnt_q + GW'(1) : '0;
        cnt_q <= cnt_d;
        seen_q <= seen_q | new_ev;
        won_q <= won_q | acc;
        inhibit_q <= inhibit_q | (state_q == ACTIVE && cnt_d >= k_eff_q);
        for (int i = 0; i < NUM_INPUTS; i++)
          pc_q[i] <= acc[i] ? PCW'(PULSE_WIDTH) : (pc_q[i] != '0 ? pc_q[i] - PCW'(1) : '0);
      end
    end
  end
endmodule

// File: tb/tb_kwta_gamma_sync.sv
// tb_kwta_gamma_sync: random and directed checks of both tie policies against a window-level model
module tb_kwta_gamma_sync;
  localparam int N = 16, G = 16, PW = 8, KW = $clog2(N + 1);
  logic clk = 1'b0, rst = 1'b1, gs = 1'b0;
  logic [KW-1:0] k = '0;
  logic [N-1:0] sp = '0;
  logic [N-1:0] os0, os1, wm0, wm1;
  logic [KW-1:0] wc0, wc1;
  logic inh0, inh1, dn0, dn1;
  int checks = 0, fails = 0;
  bit m_act [2];
  int m_pos [2], m_k [2], m_wins [2], m_cnt [2];
  bit [N-1:0] m_seen [2], m_won [2], m_mask [2];
  bit m_inh [2], m_done [2];
  int m_rem [2][N];

  always #5 clk = ~clk;

  kwta_gamma_sync #(.NUM_INPUTS(N), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .TIE_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .gamma_start_i(gs), .k_cfg_i(k), .input_spikes_i(sp),
    .output_spikes_o(os0), .inhibit_o(inh0), .winner_mask_o(wm0), .winner_count_o(wc0), .done_o(dn0));
  kwta_gamma_sync #(.NUM_INPUTS(N), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .TIE_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .gamma_start_i(gs), .k_cfg_i(k), .input_spikes_i(sp),
    .output_spikes_o(os1), .inhibit_o(inh1), .winner_mask_o(wm1), .winner_count_o(wc1), .done_o(dn1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit [N-1:0] exp_os(input int m);
    bit [N-1:0] r = '0;
    for (int i = 0; i < N; i++) r[i] = m_rem[m][i] > 0;
    return r;
  endfunction

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      bit [N-1:0] acc;
      int q[$];
      int room;
      acc = '0;
      if (rst) begin
        m_act[m] = 0; m_pos[m] = 0; m_k[m] = 0; m_wins[m] = 0; m_cnt[m] = 0;
        m_seen[m] = '0; m_won[m] = '0; m_mask[m] = '0; m_inh[m] = 0; m_done[m] = 0;
        for (int i = 0; i < N; i++) m_rem[m][i] = 0;
      end else begin
        m_done[m] = m_act[m] && m_pos[m] == G - 1 && !gs;
        if (m_act[m] && !gs) begin
          for (int i = 0; i < N; i++)
            if (sp[i] && !m_seen[m][i]) begin q.push_back(i); m_seen[m][i] = 1; end
          room = m_k[m] - m_wins[m];
          foreach (q[j]) if (room > 0 && (m == 0 || j < room)) acc[q[j]] = 1;
        end
        for (int i = 0; i < N; i++) begin
          if (m_rem[m][i] > 0) m_rem[m][i]--;
          if (acc[i]) begin m_rem[m][i] = PW; m_won[m][i] = 1; m_wins[m]++; end
        end
        if (m_act[m] && m_wins[m] >= m_k[m]) m_inh[m] = 1;
        if (m_done[m]) begin m_mask[m] = m_won[m]; m_cnt[m] = $countones(m_won[m]); end
        if (gs) begin
          m_act[m] = 1; m_pos[m] = 0; m_k[m] = (int'(k) > N) ? N : int'(k);
          m_seen[m] = '0; m_won[m] = '0; m_wins[m] = 0; m_inh[m] = m_k[m] == 0;
          for (int i = 0; i < N; i++) m_rem[m][i] = 0;
        end else if (m_act[m]) begin
          if (m_pos[m] == G - 1) m_act[m] = 0; else m_pos[m]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("os0", 32'(os0), 32'(exp_os(0)));
    check("os1", 32'(os1), 32'(exp_os(1)));
    check("inh0", 32'(inh0), 32'(m_inh[0]));
    check("inh1", 32'(inh1), 32'(m_inh[1]));
    check("done0", 32'(dn0), 32'(m_done[0]));
    check("done1", 32'(dn1), 32'(m_done[1]));
    check("mask0", 32'(wm0), 32'(m_mask[0]));
    check("mask1", 32'(wm1), 32'(m_mask[1]));
    check("cnt0", 32'(wc0), 32'(m_cnt[0]));
    check("cnt1", 32'(wc1), 32'(m_cnt[1]));
  endtask

  task automatic start(input int kv);
    gs = 1'b1;
    k = KW'(kv);
    tick();
    gs = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    run(3);
    rst = 1'b0;
    run(2);
    // first k rising in successive cycles
    start(4);
    for (int c = 0; c < 6; c++) begin
      sp = sp | N'(1 << c);
      tick();
    end
    sp = '0;
    run(12);
    check("t1_mask", 32'(wm1), 32'h000F);
    check("t1_cnt", 32'(wc1), 32'd4);
    // simultaneous spikes at the k-th slot
    start(4);
    sp = N'(16'h5288);
    tick();
    sp = '0;
    run(17);
    check("t2_mask0", 32'(wm0), 32'h5288);
    check("t2_mask1", 32'(wm1), 32'h1288);
    check("t2_cnt0", 32'(wc0), 32'd5);
    // k = 0 and k clamped above NUM_INPUTS
    start(0);
    sp = '1;
    run(17);
    sp = '0;
    run(1);
    check("t3_mask0", 32'(wm0), 32'h0);
    start(20);
    sp = '1;
    run(17);
    sp = '0;
    run(1);
    check("t3_mask_all", 32'(wm1), 32'hFFFF);
    check("t3_cnt_all", 32'(wc1), 32'd16);
    // abort mid-window with pulses in flight, then same lines win again
    start(3);
    for (int c = 0; c < 7; c++) begin
      sp = sp | N'(1 << (c + 4));
      tick();
    end
    start(3);
    run(18);
    sp = '0;
    // reset mid-pulse while inhibited, then idle toggles
    start(2);
    sp = N'(16'h0003);
    run(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      sp = N'($urandom);
      tick();
    end
    // a held line and a toggling line across two windows
    sp = N'(1 << 5);
    start(8);
    for (int c = 0; c < G + 2; c++) begin
      sp[6] = c[0];
      tick();
    end
    start(8);
    run(G + 2);
    sp = '0;
    // randomized windows: lengths straddle abort, last-cycle and at-done restarts
    for (int w = 0; w < 60; w++) begin
      int len;
      len = $urandom_range(G + 4, 1);
      if (w % 5 == 0) len = G + 1;
      start($urandom_range(31, 0));
      for (int c = 0; c < len; c++) begin
        sp = (w % 3 == 0) ? N'($urandom) : N'($urandom & $urandom & $urandom);
        tick();
      end
    end
    sp = '0;
    run(G + PW + 2);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
